fetch_stage: RTL and testbench

- Instruction fetch stage of the RV64 pipeline, directly upstream of decode/immediate generation.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions with their PCs in a small FIFO, presented to decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered instructions and discarding stale in-flight responses.

---
 rtl/fetch_stage_if.sv | 64 ++++++
 rtl/fetch_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Bus bundle for the fetch stage: instruction-memory request
//               and response channels, execute redirect, and the decode-side
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
  parameter int XLEN = 64
);

  // Instruction memory request channel
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;

  // Instruction memory response channel (in order, no backpressure)
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_instr;

  // Redirect from execute
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Decode handshake
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;

  // Fetch stage side
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_instr,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_pc,
    output id_instr
  );

  // Environment side: memory, execute and decode
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_instr,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_pc,
    input  id_instr
  );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV64 instruction fetch. Owns the PC, issues word fetches
//               under a credit limit, queues returned instructions with their
//               PCs for decode, and flushes/discards stale work on redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_stage_if.master bus
);

  // Counter width holds 0..FIFO_DEPTH; pointer width indexes the buffers.
  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int            PW        = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [31:0]   NOP       = 32'h00000013;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic            running;     // low during and one cycle after reset
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   inflight;    // accepted requests without a response yet
  logic [CW-1:0]   drop_cnt;    // outstanding responses known to be stale

  // PCs of issued requests, consumed as their responses are kept
  logic [XLEN-1:0] pcq [FIFO_DEPTH];
  logic [PW-1:0]   pcq_wp;
  logic [PW-1:0]   pcq_rp;

  // Instruction buffer presented to decode
  logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [PW-1:0]   fifo_wp;
  logic [PW-1:0]   fifo_rp;
  logic [CW-1:0]   fifo_cnt;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [CW:0] credits_used;
  logic        req_valid;
  logic        req_fire;
  logic        rsp_drop;
  logic        rsp_keep;
  logic        fifo_empty;
  logic        id_fire;
  logic        unused_redirect_lsbs;

  // Every issued-but-unconsumed fetch holds a buffer slot, so a response
  // always has room to land. Registered counts only: no same-cycle credit
  // return, which keeps the request path free of response/pop timing.
  assign credits_used = {1'b0, inflight} + {1'b0, fifo_cnt};

  // A redirect withdraws any pending request; otherwise a raised request
  // stays up because credits can only be freed while it waits.
  assign req_valid  = running && !bus.redirect_valid && (credits_used < DEPTH_EXT);
  assign req_fire   = req_valid && bus.imem_req_ready;

  // Responses are stale if an older redirect left them outstanding or a
  // redirect is happening right now.
  assign rsp_drop   = bus.imem_rsp_valid && ((drop_cnt != '0) || bus.redirect_valid);
  assign rsp_keep   = bus.imem_rsp_valid && !rsp_drop;

  assign fifo_empty = (fifo_cnt == '0);

  // A pop coinciding with a redirect is meaningless: the buffer is flushed.
  assign id_fire    = !fifo_empty && bus.id_ready && !bus.redirect_valid;

  // Redirect targets are word-aligned by discarding the low bits.
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.id_valid       = !fifo_empty;
  assign bus.id_pc          = fifo_empty ? '0  : fifo_pc[fifo_rp];
  assign bus.id_instr       = fifo_empty ? NOP : fifo_instr[fifo_rp];

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Hold off requests until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
    end else begin
      running <= 1'b1;
    end
  end

  // Program counter: redirect target wins, otherwise advance on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else if (req_fire) begin
      pc <= pc + XLEN'(4);
    end
  end

  // Outstanding request count; accept and response in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    end
  end

  // Stale-response counter. On redirect, everything still outstanding after
  // this cycle becomes stale; previously marked entries are a subset of
  // those, so the new value replaces rather than adds to the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      drop_cnt <= inflight - CW'(bus.imem_rsp_valid);
    end else if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CNT_ONE;
    end
  end

  // PC queue pointers: push on accept, pop on a kept response, clear on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcq_wp <= '0;
      pcq_rp <= '0;
    end else if (bus.redirect_valid) begin
      pcq_wp <= '0;
      pcq_rp <= '0;
    end else begin
      if (req_fire) begin
        pcq_wp <= pcq_wp + PTR_ONE;
      end
      if (rsp_keep) begin
        pcq_rp <= pcq_rp + PTR_ONE;
      end
    end
  end

  // PC queue storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq[pcq_wp] <= pc;
    end
  end

  // Instruction buffer pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      fifo_cnt <= '0;
    end else if (bus.redirect_valid) begin
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (rsp_keep) begin
        fifo_wp <= fifo_wp + PTR_ONE;
      end
      if (id_fire) begin
        fifo_rp <= fifo_rp + PTR_ONE;
      end
      fifo_cnt <= fifo_cnt + CW'(rsp_keep) - CW'(id_fire);
    end
  end

  // Instruction buffer storage: pair each kept instruction with its PC.
  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      fifo_pc[fifo_wp]    <= pcq[pcq_rp];
      fifo_instr[fifo_wp] <= bus.imem_rsp_instr;
    end
  end

  // --------------------------------------------------------------------------
  // Protocol checks (simulation only; ignored by synthesis)
  // --------------------------------------------------------------------------

  // A response with nothing outstanding means the memory broke the protocol.
  a_rsp_has_request: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> (inflight != '0)
  );

  // The credit limit guarantees a kept response always finds a free slot.
  a_rsp_not_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    rsp_keep |-> (fifo_cnt != CW'(FIFO_DEPTH))
  );

  // Credits in use never exceed the buffer depth.
  a_credit_bound: assert property (
    @(posedge clk) disable iff (!rst_n)
    credits_used <= DEPTH_EXT
  );

  // Fetch addresses stay word aligned.
  a_addr_aligned: assert property (
    @(posedge clk) disable iff (!rst_n)
    req_valid |-> (pc[1:0] == 2'b00)
  );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed bench for fetch_stage: cycle vectors for startup,
//               streaming and backpressure, plus hand sequences for
//               redirects, request hold and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   lat;

  fetch_stage_if #(.XLEN(64)) bus ();

  fetch_stage #(
    .XLEN       (64),
    .RESET_PC   (64'h0),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: accepted requests come back lat cycles later, in order.
  typedef struct {
    logic [63:0] addr;
    int          due;
  } rsp_t;
  rsp_t rspq[$];

  // Sampled DUT outputs of the most recent cycle
  logic        s_req_valid;
  logic [63:0] s_req_addr;
  logic        s_id_valid;
  logic [63:0] s_id_pc;
  logic [31:0] s_id_instr;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    case (a)
      64'h0:   instr_of = 32'h00500093;
      64'h4:   instr_of = 32'hfff00093;
      64'h8:   instr_of = 32'h00113423;
      64'hC:   instr_of = 32'hfe000ce3;
      default: instr_of = {a[19:0], 12'h0B3};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_instr = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.id_ready       = 1'b0;
  endtask

  // One clock cycle: drive inputs mid-cycle, sample outputs, then let the
  // memory model react to the handshake at the rising edge.
  task automatic tick(input logic ir, input logic mr, input logic rv, input logic [63:0] rpc);
    logic rsp_now;
    @(negedge clk);
    bus.id_ready       = ir;
    bus.imem_req_ready = mr;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    rsp_now = (rspq.size() > 0) && (rspq[0].due <= cyc);
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_instr = rsp_now ? instr_of(rspq[0].addr) : 32'h0;
    #1;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_id_valid  = bus.id_valid;
    s_id_pc     = bus.id_pc;
    s_id_instr  = bus.id_instr;
    @(posedge clk);
    if (rsp_now) void'(rspq.pop_front());
    if (s_req_valid && mr) rspq.push_back('{s_req_addr, cyc + lat});
    cyc++;
  endtask

  // Hold reset for three edges, check the reset outputs, release mid-cycle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    rspq.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'h0);
    chk("rst_id_valid",  64'(bus.id_valid),       64'h0);
    chk("rst_id_pc",     bus.id_pc,               64'h0);
    chk("rst_id_instr",  64'(bus.id_instr),       64'(NOP));
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Drain with id_ready=1 until decode sees an instruction (bounded).
  task automatic wait_id(input string nm, input logic [63:0] exp_pc);
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1, 1'b0, 64'h0);
      if (s_id_valid) break;
    end
    chk({nm, "_seen"},  64'(s_id_valid), 64'h1);
    chk({nm, "_pc"},    s_id_pc,         exp_pc);
    chk({nm, "_instr"}, 64'(s_id_instr), 64'(instr_of(exp_pc)));
  endtask

  typedef struct {
    logic        rst;     // apply reset before this vector
    logic        ir;      // id_ready
    logic        mr;      // imem_req_ready
    logic        e_rv;    // expected imem_req_valid
    logic [63:0] e_ra;    // expected imem_req_addr
    logic        e_iv;    // expected id_valid
    logic [63:0] e_ipc;   // expected id_pc
    logic [31:0] e_iin;   // expected id_instr
  } vec_t;

  vec_t vecs[18];

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    lat   = 1;
    rst_n = 1'b1;
    idle_inputs();

    // Startup + streaming, 1-cycle memory, decode always ready
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h00, 1'b0, 64'h0,  NOP};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h04, 1'b0, 64'h0,  NOP};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h08, 1'b1, 64'h0,  32'h00500093};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h0C, 1'b1, 64'h4,  32'hfff00093};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h10, 1'b1, 64'h8,  32'h00113423};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h14, 1'b1, 64'hC,  32'hfe000ce3};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h18, 1'b1, 64'h10, 32'h000100B3};
    // Backpressure: decode stalled, buffer fills, then drains
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 64'h00, 1'b0, 64'h0,  NOP};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h04, 1'b0, 64'h0,  NOP};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h08, 1'b1, 64'h0,  32'h00500093};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h0C, 1'b1, 64'h0,  32'h00500093};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h10, 1'b1, 64'h0,  32'h00500093};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h10, 1'b1, 64'h0,  32'h00500093};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h10, 1'b1, 64'h0,  32'h00500093};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h10, 1'b1, 64'h4,  32'hfff00093};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h14, 1'b1, 64'h8,  32'h00113423};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h18, 1'b1, 64'hC,  32'hfe000ce3};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h1C, 1'b1, 64'h10, 32'h000100B3};

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].rst) begin
        lat = 1;
        do_reset();
      end
      tick(vecs[i].ir, vecs[i].mr, 1'b0, 64'h0);
      chk($sformatf("v%0d_req_valid", i), 64'(s_req_valid), 64'(vecs[i].e_rv));
      chk($sformatf("v%0d_req_addr", i),  s_req_addr,       vecs[i].e_ra);
      chk($sformatf("v%0d_id_valid", i),  64'(s_id_valid),  64'(vecs[i].e_iv));
      chk($sformatf("v%0d_id_pc", i),     s_id_pc,          vecs[i].e_ipc);
      chk($sformatf("v%0d_id_instr", i),  64'(s_id_instr),  64'(vecs[i].e_iin));
    end

    // Request held stable while memory is not ready
    lat = 1;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 64'h0);
    chk("hold0_valid", 64'(s_req_valid), 64'h1);
    chk("hold0_addr",  s_req_addr,       64'h0);
    tick(1'b0, 1'b0, 1'b0, 64'h0);
    chk("hold1_valid", 64'(s_req_valid), 64'h1);
    chk("hold1_addr",  s_req_addr,       64'h0);
    tick(1'b0, 1'b1, 1'b0, 64'h0);
    chk("hold2_addr",  s_req_addr,       64'h0);
    tick(1'b0, 1'b1, 1'b0, 64'h0);
    chk("hold3_addr",  s_req_addr,       64'h4);

    // Redirect with two requests in flight, 2-cycle memory
    lat = 2;
    do_reset();
    tick(1'b0, 1'b1, 1'b0, 64'h0);            // fetch 0x0
    tick(1'b0, 1'b1, 1'b0, 64'h0);            // fetch 0x4
    tick(1'b0, 1'b1, 1'b0, 64'h0);            // fetch 0x8, rsp 0x0
    tick(1'b0, 1'b1, 1'b1, 64'h100);          // redirect, rsp 0x4 coincident
    chk("r4_req_withdrawn", 64'(s_req_valid), 64'h0);
    chk("r4_pre_id_valid",  64'(s_id_valid),  64'h1);
    tick(1'b1, 1'b1, 1'b0, 64'h0);            // rsp 0x8 stale
    chk("r4_flushed",   64'(s_id_valid), 64'h0);
    chk("r4_new_valid", 64'(s_req_valid), 64'h1);
    chk("r4_new_addr",  s_req_addr,       64'h100);
    wait_id("r4_first", 64'h100);
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    chk("r4_second_valid", 64'(s_id_valid), 64'h1);
    chk("r4_second_pc",    s_id_pc,         64'h104);

    // Misaligned redirect coincident with a response, 1-cycle memory
    lat = 1;
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 64'h0);            // fetch 0x0
    tick(1'b1, 1'b1, 1'b1, 64'h103);          // redirect, rsp 0x0 coincident
    chk("r5_req_withdrawn", 64'(s_req_valid), 64'h0);
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    chk("r5_no_stale",  64'(s_id_valid),  64'h0);
    chk("r5_new_valid", 64'(s_req_valid), 64'h1);
    chk("r5_new_addr",  s_req_addr,       64'h100);
    wait_id("r5_first", 64'h100);

    // Back-to-back redirects, 2-cycle memory: the later target wins
    lat = 2;
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 64'h0);            // fetch 0x0
    tick(1'b1, 1'b1, 1'b0, 64'h0);            // fetch 0x4
    tick(1'b1, 1'b1, 1'b1, 64'h200);          // rsp 0x0 dropped
    tick(1'b1, 1'b1, 1'b1, 64'h301);          // rsp 0x4 dropped
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    chk("bb_new_valid", 64'(s_req_valid), 64'h1);
    chk("bb_new_addr",  s_req_addr,       64'h300);
    wait_id("bb_first", 64'h300);
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    chk("bb_second_pc", s_id_pc, 64'h304);

    // Asynchronous reset with three buffered and one in flight
    lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 64'h0);
    @(negedge clk);
    #1;
    chk("ar_pre_id_valid", 64'(bus.id_valid), 64'h1);
    rst_n = 1'b0;
    rspq.delete();
    idle_inputs();
    #1;
    chk("ar_id_valid",  64'(bus.id_valid),       64'h0);
    chk("ar_req_valid", 64'(bus.imem_req_valid), 64'h0);
    chk("ar_id_instr",  64'(bus.id_instr),       64'(NOP));
    chk("ar_id_pc",     bus.id_pc,               64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    chk("ar_restart_valid", 64'(s_req_valid), 64'h1);
    chk("ar_restart_addr",  s_req_addr,       64'h0);
    chk("ar_empty",         64'(s_id_valid),  64'h0);
    wait_id("ar_first", 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule : tb_fetch_stage
`default_nettype wire
